clk_enable_mc: RTL

- Parametrised multi-channel clock-enable generator; each channel emits a one-cycle enable strobe every DIV cycles of the single system clock.
- Per-channel runtime divisor, phase offset, and periodic or one-shot mode.
- Serves line-buffer, pixel-pipeline and sampling stages that need slower, phase-aligned strobes instead of derived clocks.
- With defaults, channel 0 after reset gives one strobe every 8 cycles (legacy divide-by-8 timing).

---
 rtl/clk_enable_pkg.sv | 36 +++
 rtl/clk_enable_ch.sv | 99 +++++++++
 rtl/clk_enable_mc.sv | 64 ++++++
 3 files changed

// File: rtl/clk_enable_pkg.sv
// Shared definitions for the multi-channel clock-enable generator.
// Holds the mode encodings, the channel state type, the config-check result
// codes, and helpers for the channel-index width and config validation.
package clk_enable_pkg;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

   // Result codes of a config-write check. Any non-OK code rejects the write.
   localparam logic [1:0] CFG_OK        = 2'd0;
   localparam logic [1:0] CFG_ERR_DIV   = 2'd1;
   localparam logic [1:0] CFG_ERR_CH    = 2'd2;
   localparam logic [1:0] CFG_ERR_PHASE = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ch_state_e;

   // Width of a channel index; at least one bit, even for a single channel.
   function automatic int unsigned ch_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Classify a config write. A zero divisor is reported first.
   function automatic logic [1:0] cfg_check(input int unsigned div,
                                            input int unsigned phase,
                                            input int unsigned ch,
                                            input int unsigned num_ch);
      if (div == 0)          return CFG_ERR_DIV;
      else if (ch >= num_ch) return CFG_ERR_CH;
      else if (phase >= div) return CFG_ERR_PHASE;
      else                   return CFG_OK;
   endfunction

endpackage

// File: rtl/clk_enable_ch.sv
// One enable channel: divisor/phase/mode registers, counter, run state and
// strobe decode.
// Ports: clk, rst_n (async active-low), en (global run), clr (realign),
//        wr (accepted config write to this channel) with wr_div/wr_phase/
//        wr_mode, start (one-shot trigger), strobe_c (enable strobe),
//        busy (channel counting).
module clk_enable_ch
   import clk_enable_pkg::*;
#(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned DEFAULT_DIV = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   input  logic [CNT_W-1:0] wr_phase,
   input  logic             wr_mode,
   input  logic             start,
   output logic             strobe_c,
   output logic             busy
);

   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mode_q, mode_d;
   ch_state_e        state_q, state_d;
   logic             at_end;

   assign at_end = (count_q == div_q - CNT_W'(1));

   // Strobe is suppressed in any cycle that reloads the channel.
   assign strobe_c = (state_q == ST_RUN) && en && at_end && !clr && !wr;
   assign busy     = (state_q == ST_RUN);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= CNT_W'(DEFAULT_DIV);
         phase_q <= '0;
         count_q <= '0;
         mode_q  <= MODE_PERIODIC;
         state_q <= ST_RUN;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         state_q <= state_d;
      end
   end

   // Next state: config write, then clear, then counting.
   always_comb begin
      div_d   = div_q;
      phase_d = phase_q;
      count_d = count_q;
      mode_d  = mode_q;
      state_d = state_q;
      if (wr) begin
         // A write coinciding with clear still loads the new phase.
         div_d   = wr_div;
         phase_d = wr_phase;
         mode_d  = wr_mode;
         count_d = wr_phase;
         state_d = (wr_mode == MODE_PERIODIC) ? ST_RUN : ST_IDLE;
      end else if (clr) begin
         count_d = phase_q;
         state_d = (mode_q == MODE_PERIODIC) ? ST_RUN : ST_IDLE;
      end else if (en) begin
         unique case (state_q)
            ST_RUN: begin
               if (at_end) begin
                  if (mode_q == MODE_ONESHOT) begin
                     count_d = phase_q;
                     state_d = ST_IDLE;
                  end else begin
                     count_d = '0;
                  end
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
            ST_IDLE: begin
               // Only one-shot channels can be idle, so start needs no mode test.
               if (start) begin
                  count_d = phase_q;
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

endmodule

// File: rtl/clk_enable_mc.sv
// Multi-channel clock-enable generator: per-channel strobe every DIV cycles
// with runtime divisor, phase offset and periodic/one-shot mode.
// Ports: iClk, iRst (async active-low), iEn (global run), iClr (realign all),
//        iCfgWe/iCfgCh/iCfgDiv/iCfgPhase/iCfgMode (config write),
//        iStart (one-shot triggers), oEnable (strobes), oBusy (counting),
//        oCfgErr (pulse after a rejected config write).
module clk_enable_mc
   import clk_enable_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned DEFAULT_DIV = 8
) (
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic                      iEn,
   input  logic                      iClr,
   input  logic                      iCfgWe,
   input  logic [ch_w(NUM_CH)-1:0]   iCfgCh,
   input  logic [CNT_W-1:0]          iCfgDiv,
   input  logic [CNT_W-1:0]          iCfgPhase,
   input  logic                      iCfgMode,
   input  logic [NUM_CH-1:0]         iStart,
   output logic [NUM_CH-1:0]         oEnable,
   output logic [NUM_CH-1:0]         oBusy,
   output logic                      oCfgErr
);

   logic [1:0] cfg_code_c;
   logic       cfg_ok_c;

   // Validate the write in 32 bits so an out-of-range channel is caught for any NUM_CH.
   assign cfg_code_c = cfg_check(32'(iCfgDiv), 32'(iCfgPhase), 32'(iCfgCh), NUM_CH);
   assign cfg_ok_c   = iCfgWe && (cfg_code_c == CFG_OK);

   // Error pulse, one cycle after a rejected write.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) oCfgErr <= 1'b0;
      else       oCfgErr <= iCfgWe && (cfg_code_c != CFG_OK);
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic wr_c;
      assign wr_c = cfg_ok_c && (32'(iCfgCh) == 32'(c));

      clk_enable_ch #(
         .CNT_W      (CNT_W),
         .DEFAULT_DIV(DEFAULT_DIV)
      ) u_ch (
         .clk      (iClk),
         .rst_n    (iRst),
         .en       (iEn),
         .clr      (iClr),
         .wr       (wr_c),
         .wr_div   (iCfgDiv),
         .wr_phase (iCfgPhase),
         .wr_mode  (iCfgMode),
         .start    (iStart[c]),
         .strobe_c (oEnable[c]),
         .busy     (oBusy[c])
      );
   end

endmodule
